// File: rtl/sb_pkg.sv
// sb_pkg: framing constants, arbiter state type and the round-robin successor helper.
package sb_pkg;

  localparam logic [7:0] SB_DLE = 8'hFE;
  localparam logic [7:0] SB_STX = 8'h05;
  localparam logic [7:0] SB_ETX = 8'h40;

  typedef enum logic [2:0] {
    IDLE,
    HDR_DLE,
    HDR_STX,
    PAYLOAD,
    STUFF,
    TRL_DLE,
    TRL_ETX,
    GAP
  } sb_arb_state_t;

  // Next round-robin start after a grant to 'win'; requester 0 is outside the ring.
  function automatic int unsigned rr_succ(input int unsigned win, input int unsigned nreq);
    return (win + 1 >= nreq) ? 1 : win + 1;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: combinational pick; requester 0 has fixed priority, the rest round-robin from rr_ptr.
module sb_rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan 1..NREQ-1 starting at rr_ptr, first requester found wins
  always_comb begin
    onehot = '0;
    id     = '0;
    found  = 1'b0;
    idx    = '0;
    any    = |req;
    if (req[0]) begin
      onehot[0] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ - 1; k++) begin
        idx = IDW'(((32'(rr_ptr) + k - 1) % (NREQ - 1)) + 1);
        if (!found && req[idx]) begin
          found       = 1'b1;
          onehot[idx] = 1'b1;
          id          = idx;
        end
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: shares the sideband byte transmit path between NREQ requesters, framing each
// transaction as DLE STX <payload> DLE ETX followed by a forced idle gap.
// Optional feature macro: SB_DLE_STUFF_EN (payload DLE bytes are emitted twice).
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned GAP_CYC = 2,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              sb_tx_disable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              len_err
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sb_arb_state_t   state, state_nxt;
  logic [NREQ-1:0] grant_oh, grant_oh_nxt, win_oh;
  logic [IDW-1:0]  grant_id_nxt, win_id, rr_ptr, rr_nxt;
  logic            win_any;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [7:0]      tx_data_nxt, cur_data;
  logic            tx_valid_nxt, busy_nxt, len_err_nxt;
  logic            load, grant_ok, cur_valid, cur_last, take, trunc, close_req;
`ifdef SB_DLE_STUFF_EN
  logic            stuff_end, stuff_end_nxt;
`endif

  sb_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .onehot (win_oh),
    .id     (win_id),
    .any    (win_any)
  );

  // Byte currently offered by the owner of the frame
  always_comb begin
    cur_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) cur_data = cur_data | req_data[8*i +: 8];
    end
  end

  assign load      = !tx_valid || tx_ready;
  assign cur_valid = |(req_valid & grant_oh);
  assign cur_last  = |(req_last & grant_oh);
  assign take      = (state == PAYLOAD) && load && cur_valid;
  assign cnt_inc   = cnt + CW'(1);
  assign trunc     = take && !cur_last && (cnt_inc == CW'(MAX_LEN));
  assign close_req = cur_last || trunc || sb_tx_disable;
  assign grant_ok  = (state == IDLE) && !sb_tx_disable && win_any;
  assign req_ready = grant_oh & {NREQ{take && !rst}};

  // State register
  always_ff @(posedge sb_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: each emit state advances when its byte enters the output register
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = HDR_DLE;
      HDR_DLE: if (load) state_nxt = sb_tx_disable ? TRL_DLE : HDR_STX;
      HDR_STX: if (load) state_nxt = sb_tx_disable ? TRL_DLE : PAYLOAD;
      PAYLOAD: begin
        if (load) begin
          if (cur_valid) begin
`ifdef SB_DLE_STUFF_EN
            if (cur_data == SB_DLE) state_nxt = STUFF;
            else
`endif
            if (close_req) state_nxt = TRL_DLE;
          end else if (sb_tx_disable) begin
            state_nxt = TRL_DLE;
          end
        end
      end
`ifdef SB_DLE_STUFF_EN
      STUFF:   if (load) state_nxt = (stuff_end || sb_tx_disable) ? TRL_DLE : PAYLOAD;
`endif
      TRL_DLE: if (load) state_nxt = TRL_ETX;
      TRL_ETX: if (load) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:     if (!tx_valid && (gap_cnt == GW'(GAP_CYC - 1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values: output register load, grant capture, counters
  always_comb begin
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    grant_id_nxt = grant_id;
    grant_oh_nxt = grant_oh;
    rr_nxt       = rr_ptr;
    cnt_nxt      = cnt;
    gap_nxt      = gap_cnt;
    len_err_nxt  = 1'b0;
`ifdef SB_DLE_STUFF_EN
    stuff_end_nxt = stuff_end;
`endif
    if (load) tx_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        gap_nxt = '0;
        if (grant_ok) begin
          grant_id_nxt = win_id;
          grant_oh_nxt = win_oh;
          rr_nxt       = IDW'(rr_succ(32'(win_id), NREQ));
        end
      end
      HDR_DLE, TRL_DLE: begin
        if (load) begin
          tx_data_nxt  = SB_DLE;
          tx_valid_nxt = 1'b1;
        end
      end
      HDR_STX: begin
        if (load) begin
          tx_data_nxt  = SB_STX;
          tx_valid_nxt = 1'b1;
        end
      end
      PAYLOAD: begin
        if (take) begin
          tx_data_nxt  = cur_data;
          tx_valid_nxt = 1'b1;
          cnt_nxt      = cnt_inc;
          len_err_nxt  = trunc;
`ifdef SB_DLE_STUFF_EN
          stuff_end_nxt = close_req;
`endif
        end
      end
`ifdef SB_DLE_STUFF_EN
      STUFF: begin
        if (load) begin
          tx_data_nxt  = SB_DLE;
          tx_valid_nxt = 1'b1;
        end
      end
`endif
      TRL_ETX: begin
        if (load) begin
          tx_data_nxt  = SB_ETX;
          tx_valid_nxt = 1'b1;
        end
      end
      GAP: begin
        if (!tx_valid) gap_nxt = gap_cnt + GW'(1);
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Registered outputs and bookkeeping
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      grant_id <= '0;
      grant_oh <= '0;
      rr_ptr   <= IDW'(1);
      cnt      <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      len_err  <= 1'b0;
`ifdef SB_DLE_STUFF_EN
      stuff_end <= 1'b0;
`endif
    end else begin
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      grant_id <= grant_id_nxt;
      grant_oh <= grant_oh_nxt;
      rr_ptr   <= rr_nxt;
      cnt      <= cnt_nxt;
      gap_cnt  <= gap_nxt;
      busy     <= busy_nxt;
      len_err  <= len_err_nxt;
`ifdef SB_DLE_STUFF_EN
      stuff_end <= stuff_end_nxt;
`endif
    end
  end

endmodule
